// File: rtl/rmt_rr_arbiter.sv
// rmt_rr_arbiter
// Packet-granular round-robin arbiter. It merges PORTS AXI-stream ingress
// ports into the single rmt classifier input. One port is granted per frame,
// and the grant is held until that frame's tlast beat is accepted, so frames
// are never interleaved. Every beat is tagged with its source port on
// m_axis_tid. The output has a single register stage.
// Optional build macro: RMT_ARB_STATS_EN adds per-port frame counters
// (stat_frames) with a synchronous clear input (stat_clear).
module rmt_rr_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 8,
    parameter int ID_WIDTH   = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS-1:0]              s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic                          busy
`ifdef RMT_ARB_STATS_EN
    ,
    input  logic                          stat_clear,
    output logic [PORTS*CNT_WIDTH-1:0]    stat_frames
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Reject parameter combinations the index arithmetic cannot handle.
    if (PORTS < 2 || PORTS > 16 || ID_WIDTH != $clog2(PORTS) ||
        KEEP_WIDTH * 8 != DATA_WIDTH || CNT_WIDTH < 1) begin : g_param_check
        $error("rmt_rr_arbiter: illegal parameter combination");
    end

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    grant_q, grant_d;
    logic [ID_WIDTH-1:0]    grant_next;
    logic [ID_WIDTH-1:0]    pick_idx;
    logic                   pick_found;
    logic [ID_WIDTH:0]      scan_sum;

    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0]  m_keep_q, m_keep_d;
    logic [USER_WIDTH-1:0]  m_user_q, m_user_d;
    logic [ID_WIDTH-1:0]    m_tid_q, m_tid_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;

    logic                   xfer_ready;
    logic                   beat_fire;
    logic                   frame_done;

    logic [DATA_WIDTH-1:0]  s_data_arr [PORTS];
    logic [KEEP_WIDTH-1:0]  s_keep_arr [PORTS];
    logic [USER_WIDTH-1:0]  s_user_arr [PORTS];

    // Per-port views of the flattened ingress buses and per-port ready.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        assign s_data_arr[gi]    = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign s_keep_arr[gi]    = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        assign s_user_arr[gi]    = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
        assign s_axis_tready[gi] = xfer_ready && (grant_q == ID_WIDTH'(gi));
    end

    // The granted port may push whenever the output register is empty or draining.
    assign xfer_ready = (state_q == ST_XFER) && (!m_valid_q || m_axis_tready);
    assign beat_fire  = xfer_ready && s_axis_tvalid[grant_q];
    assign frame_done = beat_fire && s_axis_tlast[grant_q];
    assign grant_next = (grant_q == ID_WIDTH'(PORTS - 1)) ? '0 : grant_q + ID_WIDTH'(1);

    // Scan requests starting at rr_ptr and wrapping; the first valid port wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        for (int k = 0; k < PORTS; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
            if (scan_sum >= (ID_WIDTH + 1)'(PORTS)) begin
                scan_sum = scan_sum - (ID_WIDTH + 1)'(PORTS);
            end
            if (!pick_found && s_axis_tvalid[scan_sum[ID_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_sum[ID_WIDTH-1:0];
            end
        end
    end

    // Next state, grant and pointer, plus loading the output register.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q && !m_axis_tready;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        m_tid_d   = m_tid_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (frame_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_arr[grant_q];
            m_keep_d  = s_keep_arr[grant_q];
            m_user_d  = s_user_arr[grant_q];
            m_last_d  = s_axis_tlast[grant_q];
            m_tid_d   = grant_q;
        end
    end

    // State and output registers; reset discards any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
            m_tid_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            m_tid_q   <= m_tid_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tid    = m_tid_q;
    assign busy          = (state_q == ST_XFER);

`ifdef RMT_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q [PORTS];
    logic [CNT_WIDTH-1:0] frame_cnt_d [PORTS];

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_stats
        // Count completed frames per port; clear takes priority over a count.
        always_comb begin
            frame_cnt_d[gi] = frame_cnt_q[gi];
            if (stat_clear) begin
                frame_cnt_d[gi] = '0;
            end else if (frame_done && (grant_q == ID_WIDTH'(gi))) begin
                frame_cnt_d[gi] = frame_cnt_q[gi] + CNT_WIDTH'(1);
            end
        end

        // Counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                frame_cnt_q[gi] <= '0;
            end else begin
                frame_cnt_q[gi] <= frame_cnt_d[gi];
            end
        end

        assign stat_frames[gi*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_rmt_rr_arbiter.sv
// Directed bench for rmt_rr_arbiter: per-port frame sources feed the DUT one
// cycle at a time, output beats are captured into queues and compared against
// hand-computed sequences.
module tb_rmt_rr_arbiter;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 8;
    localparam int IW = 2;
    localparam int CW = 8;

    logic              clk;
    logic              rst_n;
    logic [P*DW-1:0]   s_data;
    logic [P*KW-1:0]   s_keep;
    logic [P-1:0]      s_valid;
    logic [P-1:0]      s_ready;
    logic [P-1:0]      s_last;
    logic [P*UW-1:0]   s_user;
    logic [DW-1:0]     m_data;
    logic [KW-1:0]     m_keep;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [UW-1:0]     m_user;
    logic [IW-1:0]     m_tid;
    logic              busy;
`ifdef RMT_ARB_STATS_EN
    logic              stat_clear;
    logic [P*CW-1:0]   stat_frames;
`endif

    rmt_rr_arbiter #(
        .PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .USER_WIDTH(UW), .ID_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_data),
        .s_axis_tkeep(s_keep),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tlast(s_last),
        .s_axis_tuser(s_user),
        .m_axis_tdata(m_data),
        .m_axis_tkeep(m_keep),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tlast(m_last),
        .m_axis_tuser(m_user),
        .m_axis_tid(m_tid),
        .busy(busy)
`ifdef RMT_ARB_STATS_EN
        ,
        .stat_clear(stat_clear),
        .stat_frames(stat_frames)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source model: per-port list of beats, a read index and an enable for gaps.
    logic [DW-1:0] pd [P][32];
    bit            pl [P][32];
    int            pn [P];
    int            pi [P];
    bit            pen [P];

    // Captured output beats.
    logic [DW-1:0] oq_data [$];
    int            oq_tid  [$];
    bit            oq_last [$];
    int            oq_t    [$];
    int            tick_n;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int p, input int fid, input int b);
        exp_data = {8'(p), 8'(fid), 16'(b)};
    endfunction

    task automatic load_frame(input int p, input int nb, input int fid);
        for (int b = 0; b < nb; b++) begin
            pd[p][pn[p]] = exp_data(p, fid, b);
            pl[p][pn[p]] = (b == nb - 1);
            pn[p]++;
        end
    endtask

    task automatic clear_sources();
        for (int p = 0; p < P; p++) begin
            pn[p]  = 0;
            pi[p]  = 0;
            pen[p] = 1'b1;
        end
        oq_data.delete();
        oq_tid.delete();
        oq_last.delete();
        oq_t.delete();
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < P; p++) begin
            logic v;
            v = pen[p] && (pi[p] < pn[p]);
            s_valid[p]          = v;
            s_data[p*DW +: DW]  = v ? pd[p][pi[p]] : '0;
            s_last[p]           = v ? pl[p][pi[p]] : 1'b0;
            s_keep[p*KW +: KW]  = (v && pl[p][pi[p]]) ? 4'h3 : 4'hF;
            s_user[p*UW +: UW]  = 8'(p * 16 + pi[p]);
        end
    endtask

    // One clock: drive at negedge, note handshakes, advance sources after posedge.
    task automatic tick();
        bit fire [P];
        drive_inputs();
        #1;
        for (int p = 0; p < P; p++) fire[p] = s_valid[p] && s_ready[p];
        if (m_valid && m_ready) begin
            oq_data.push_back(m_data);
            oq_tid.push_back(int'(m_tid));
            oq_last.push_back(m_last);
            oq_t.push_back(tick_n);
            $display("beat t=%0d tid=%0d data=%08h last=%0b", tick_n, m_tid, m_data, m_last);
        end
        @(posedge clk);
        for (int p = 0; p < P; p++) if (fire[p]) pi[p]++;
        @(negedge clk);
        tick_n++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Tick until n beats are captured (bounded), then a few more to catch extras.
    task automatic run_until(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (oq_data.size() < n && c < budget) begin
            tick();
            c++;
        end
        repeat (3) tick();
        check({tag, "_count"}, 64'(oq_data.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_p [5];
        n_checks = 0;
        n_pass   = 0;
        tick_n   = 0;
        m_ready  = 1'b1;
`ifdef RMT_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        rst_n = 1'b0;
        clear_sources();

        // Reset state, with a request present that must not be accepted.
        load_frame(0, 3, 0);
        drive_inputs();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_busy",  64'(busy),    64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_tid",   64'(m_tid),   64'd0);
        check("rst_data",  64'(m_data),  64'd0);
        check("rst_last",  64'(m_last),  64'd0);
        rst_n = 1'b1;

        // Single port, 3-beat frame.
        tick();
        check("t1_busy_grant", 64'(busy),    64'd1);
        check("t1_bubble",     64'(m_valid), 64'd0);
        check("t1_sready",     64'(s_ready), 64'h1);
        tick();
        check("t1_b0_valid", 64'(m_valid), 64'd1);
        check("t1_b0_data",  64'(m_data),  64'(exp_data(0, 0, 0)));
        check("t1_b0_tid",   64'(m_tid),   64'd0);
        check("t1_b0_last",  64'(m_last),  64'd0);
        tick();
        check("t1_b1_data",  64'(m_data),  64'(exp_data(0, 0, 1)));
        check("t1_b1_user",  64'(m_user),  64'h01);
        tick();
        check("t1_b2_data",  64'(m_data),  64'(exp_data(0, 0, 2)));
        check("t1_b2_last",  64'(m_last),  64'd1);
        check("t1_b2_keep",  64'(m_keep),  64'h3);
        check("t1_busy_low", 64'(busy),    64'd0);
        tick();
        check("t1_drained",  64'(m_valid), 64'd0);
        check("t1_count",    64'(oq_data.size()), 64'd3);

        // All four ports with 2-beat frames from reset: order 0,1,2,3,0.
        do_reset();
        load_frame(0, 2, 0);
        load_frame(0, 2, 1);
        load_frame(1, 2, 0);
        load_frame(2, 2, 0);
        load_frame(3, 2, 0);
        run_until(10, 60, "t2");
        exp_p = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 10 && i < oq_data.size(); i++) begin
            check($sformatf("t2_tid%0d", i),  64'(oq_tid[i]),  64'(exp_p[i/2]));
            check($sformatf("t2_data%0d", i), 64'(oq_data[i]), 64'(exp_data(exp_p[i/2], (i/2 == 4) ? 1 : 0, i % 2)));
            check($sformatf("t2_last%0d", i), 64'(oq_last[i]), 64'(i % 2));
        end
        for (int i = 0; i < 9 && i + 1 < oq_t.size(); i++) begin
            check($sformatf("t2_gap%0d", i), 64'(oq_t[i+1] - oq_t[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
        end

        // Backpressure: output held for 5 cycles, ingress stalled.
        do_reset();
        load_frame(0, 4, 0);
        repeat (3) tick();
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("t3_hold_data%0d", c),  64'(m_data),  64'(exp_data(0, 0, 1)));
            check($sformatf("t3_hold_valid%0d", c), 64'(m_valid), 64'd1);
            check($sformatf("t3_hold_ready%0d", c), 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        run_until(4, 20, "t3");
        for (int i = 0; i < 4 && i < oq_data.size(); i++) begin
            check($sformatf("t3_data%0d", i), 64'(oq_data[i]), 64'(exp_data(0, 0, i)));
        end

        // Mid-frame ingress gap on the granted port while port1 waits.
        do_reset();
        load_frame(0, 3, 0);
        load_frame(1, 2, 0);
        repeat (2) tick();
        pen[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t4_busy%0d", c),   64'(busy),    64'd1);
            check($sformatf("t4_valid%0d", c),  64'(m_valid), 64'd0);
            check($sformatf("t4_sready%0d", c), 64'(s_ready), 64'h1);
        end
        pen[0] = 1'b1;
        run_until(5, 30, "t4");
        for (int i = 0; i < 5 && i < oq_data.size(); i++) begin
            check($sformatf("t4_tid%0d", i),  64'(oq_tid[i]),  (i < 3) ? 64'd0 : 64'd1);
            check($sformatf("t4_data%0d", i), 64'(oq_data[i]), 64'((i < 3) ? exp_data(0, 0, i) : exp_data(1, 0, i - 3)));
        end

        // Single-beat frames on ports 2 and 3.
        do_reset();
        load_frame(2, 1, 0);
        load_frame(3, 1, 0);
        run_until(2, 20, "t5");
        if (oq_data.size() >= 2) begin
            check("t5_tid0",  64'(oq_tid[0]),  64'd2);
            check("t5_last0", 64'(oq_last[0]), 64'd1);
            check("t5_data0", 64'(oq_data[0]), 64'(exp_data(2, 0, 0)));
            check("t5_tid1",  64'(oq_tid[1]),  64'd3);
            check("t5_last1", 64'(oq_last[1]), 64'd1);
            check("t5_data1", 64'(oq_data[1]), 64'(exp_data(3, 0, 0)));
        end

        // Reset asserted mid-frame on port1, then port0 wins the first contest.
        do_reset();
        load_frame(0, 2, 0);
        load_frame(1, 4, 0);
        repeat (5) tick();
        check("t6_pre_valid", 64'(m_valid), 64'd1);
        check("t6_pre_tid",   64'(m_tid),   64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(m_valid), 64'd0);
        check("t6_rst_busy",  64'(busy),    64'd0);
        check("t6_rst_ready", 64'(s_ready), 64'd0);
        clear_sources();
        drive_inputs();
        repeat (2) @(negedge clk);
        load_frame(0, 1, 1);
        load_frame(1, 1, 1);
        rst_n = 1'b1;
        run_until(2, 20, "t6");
        if (oq_data.size() >= 2) begin
            check("t6_first_tid",  64'(oq_tid[0]), 64'd0);
            check("t6_second_tid", 64'(oq_tid[1]), 64'd1);
        end

`ifdef RMT_ARB_STATS_EN
        // Frame counters: 5 frames on port1, then clear coinciding with a tlast.
        do_reset();
        for (int f = 0; f < 5; f++) load_frame(1, 1, f);
        run_until(5, 60, "t7");
        check("t7_cnt1",  64'(stat_frames[1*CW +: CW]), 64'd5);
        check("t7_cnt0",  64'(stat_frames[0*CW +: CW]), 64'd0);
        load_frame(1, 1, 5);
        oq_data.delete();
        oq_tid.delete();
        oq_last.delete();
        oq_t.delete();
        tick();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        tick();
        check("t7_clear_cnt1", 64'(stat_frames[1*CW +: CW]), 64'd0);
        check("t7_clear_beat", 64'(oq_data.size()), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
